svm_decision_controller: RTL

SVM_DECISION_CONTROLLER -- requirements
Module: svm_decision_controller

---
 rtl/svm_decision_controller.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/svm_decision_controller.sv
// Two-modality SVM decision controller: kernel row products, then alpha-weighted sums,
// for the V and A feature vectors in turn, against an external one-cycle-latency memory.
module svm_decision_controller #(
    parameter int NBITS         = 16,
    parameter int F_WIDTH       = 214,
    parameter int SUP_WIDTH     = 64,
    parameter int LOG_SUP_WIDTH = $clog2(SUP_WIDTH),
    parameter int LOG_MIDX      = LOG_SUP_WIDTH,
    parameter int KSHIFT        = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NBITS*F_WIDTH-1:0]         v_features,
    input  logic [NBITS*F_WIDTH-1:0]         a_features,
    output logic [LOG_MIDX-1:0]              midx,
    output logic [LOG_SUP_WIDTH-1:0]         comp_sidx,
    output logic                             computing_v_matmul1,
    output logic                             computing_v_matmul2,
    output logic                             computing_a_matmul1,
    output logic                             computing_a_matmul2,
    input  logic [NBITS*F_WIDTH-1:0]         v_support,
    input  logic [NBITS*F_WIDTH-1:0]         a_support,
    input  logic [NBITS-1:0]                 v_alpha,
    input  logic [NBITS-1:0]                 a_alpha,
    input  logic [2*NBITS+LOG_SUP_WIDTH-1:0] v_intercept,
    input  logic [2*NBITS+LOG_SUP_WIDTH-1:0] a_intercept,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [2*NBITS+LOG_SUP_WIDTH:0]   v_score,
    output logic [2*NBITS+LOG_SUP_WIDTH:0]   a_score,
    output logic                             v_label,
    output logic                             a_label
);

    localparam int DW = 2*NBITS + $clog2(F_WIDTH);
    localparam int AW = 2*NBITS + LOG_SUP_WIDTH;
    localparam int SW = AW + 1;
    localparam int PW = LOG_SUP_WIDTH + 1;
    localparam logic [PW-1:0] LAST_POS = PW'(SUP_WIDTH);
    localparam logic [LOG_SUP_WIDTH-1:0] LAST_IDX = LOG_SUP_WIDTH'(SUP_WIDTH - 1);
    localparam logic signed [DW-1:0] SAT_HI = DW'((2**(NBITS-1)) - 1);
    localparam logic signed [DW-1:0] SAT_LO = -SAT_HI - DW'(1);

    typedef enum logic [2:0] {IDLE, V_MM1, V_MM2, A_MM1, A_MM2, DONE} state_t;

    state_t state, state_next;

    logic [PW-1:0]                   pos;
    logic                            drain;
    logic [LOG_SUP_WIDTH-1:0]        idx;
    logic [LOG_SUP_WIDTH-1:0]        kidx;
    logic                            mm1, mm2, use_a;
    logic [NBITS*F_WIDTH-1:0]        v_feat_q, a_feat_q;
    logic [NBITS*F_WIDTH-1:0]        feat_sel, sup_sel;
    logic signed [NBITS-1:0]         alpha_sel;
    logic signed [AW-1:0]            icpt_sel;
    logic signed [DW-1:0]            dot, shifted;
    logic signed [NBITS-1:0]         k_sat;
    logic signed [NBITS-1:0]         kbuf [SUP_WIDTH];
    logic signed [NBITS-1:0]         k_rd;
    logic signed [2*NBITS-1:0]       prod;
    logic signed [AW-1:0]            acc, acc_next;
    logic signed [SW-1:0]            score_next;

    function automatic logic signed [DW-1:0] dot_product(
        input logic [NBITS*F_WIDTH-1:0] x,
        input logic [NBITS*F_WIDTH-1:0] y
    );
        logic signed [DW-1:0]      sum;
        logic signed [NBITS-1:0]   xa, ya;
        logic signed [2*NBITS-1:0] p;
        sum = '0;
        for (int f = 0; f < F_WIDTH; f++) begin
            xa  = x[f*NBITS +: NBITS];
            ya  = y[f*NBITS +: NBITS];
            p   = xa * ya;
            sum = sum + DW'(p);
        end
        return sum;
    endfunction

    // pos runs 0..SUP_WIDTH; the final value is the drain cycle where the index is held.
    assign drain = (pos == LAST_POS);
    assign idx   = drain ? LAST_IDX : pos[LOG_SUP_WIDTH-1:0];
    assign kidx  = drain ? LAST_IDX : (pos[LOG_SUP_WIDTH-1:0] - LOG_SUP_WIDTH'(1));

    assign mm1   = (state == V_MM1) || (state == A_MM1);
    assign mm2   = (state == V_MM2) || (state == A_MM2);
    assign use_a = (state == A_MM1) || (state == A_MM2);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and both hold until the transfer.
    always_comb begin
        state_next          = state;
        in_ready            = 1'b0;
        out_valid           = 1'b0;
        computing_v_matmul1 = 1'b0;
        computing_v_matmul2 = 1'b0;
        computing_a_matmul1 = 1'b0;
        computing_a_matmul2 = 1'b0;
        midx                = '0;
        comp_sidx           = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = V_MM1;
            end
            V_MM1: begin
                computing_v_matmul1 = 1'b1;
                midx                = LOG_MIDX'(idx);
                if (drain) state_next = V_MM2;
            end
            V_MM2: begin
                computing_v_matmul2 = 1'b1;
                comp_sidx           = idx;
                if (drain) state_next = A_MM1;
            end
            A_MM1: begin
                computing_a_matmul1 = 1'b1;
                midx                = LOG_MIDX'(idx);
                if (drain) state_next = A_MM2;
            end
            A_MM2: begin
                computing_a_matmul2 = 1'b1;
                comp_sidx           = idx;
                if (drain) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign feat_sel  = use_a ? a_feat_q : v_feat_q;
    assign sup_sel   = use_a ? a_support : v_support;
    assign alpha_sel = use_a ? a_alpha : v_alpha;
    assign icpt_sel  = use_a ? a_intercept : v_intercept;

    always_comb begin
        dot     = dot_product(feat_sel, sup_sel);
        shifted = dot >>> KSHIFT;
        k_sat   = shifted[NBITS-1:0];
        if (shifted > SAT_HI)      k_sat = SAT_HI[NBITS-1:0];
        else if (shifted < SAT_LO) k_sat = SAT_LO[NBITS-1:0];
    end

    // Memory data seen at pos p belongs to index p-1, presented one cycle earlier.
    assign k_rd       = kbuf[kidx];
    assign prod       = alpha_sel * k_rd;
    assign acc_next   = acc + AW'(prod);
    assign score_next = SW'(acc_next) + SW'(icpt_sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            pos      <= '0;
            v_feat_q <= '0;
            a_feat_q <= '0;
            acc      <= '0;
            v_score  <= '0;
            a_score  <= '0;
            v_label  <= 1'b0;
            a_label  <= 1'b0;
            for (int i = 0; i < SUP_WIDTH; i++) kbuf[i] <= '0;
        end else begin
            if (mm1 || mm2) pos <= drain ? '0 : pos + PW'(1);
            else            pos <= '0;

            if (state == IDLE && in_valid) begin
                v_feat_q <= v_features;
                a_feat_q <= a_features;
            end

            if (mm1 && pos != '0) kbuf[kidx] <= k_sat;

            // The accumulator is zeroed throughout MM1 so each MM2 starts clean.
            if (mm1)                   acc <= '0;
            else if (mm2 && pos != '0) acc <= acc_next;

            if (mm2 && drain) begin
                if (use_a) begin
                    a_score <= score_next;
                    a_label <= ~score_next[SW-1];
                end else begin
                    v_score <= score_next;
                    v_label <= ~score_next[SW-1];
                end
            end
        end
    end

endmodule
